jpeg_stream_arb: RTL and testbench
==================================

// Module: jpeg_stream_arb
// PURPOSE
//  - Frame-granular arbiter: shares one jpeg_core input stream among NUM_REQ JPEG byte-stream requesters.
//  - Grants one requester per image, switching only at an image boundary (inport_last beat accepted).
//  - After that boundary, waits until the core's decode pipeline has drained, then re-arbitrates.
//  - owner_id_o tags which requester the current pixel stream from jpeg_core belongs to.
// PARAMETERS
//  NUM_REQ      4   number of requesters, 1..8
//  ID_W         2   owner id width, >= clog2(NUM_REQ) and >= 1
//  IDLE_CYCLES  4   consecutive cycles core_idle_i must be high before a DRAIN completes, 1..255
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          reset, asynchronous, active-low
//  req_valid_i    in   NUM_REQ    per-requester beat valid
//  req_data_i     in   NUM_REQ*32 per-requester data; requester k uses bits [32k+31:32k]
//  req_strb_i     in   NUM_REQ*4  per-requester byte strobes
//  req_last_i     in   NUM_REQ    final beat of the requester's image
//  req_accept_o   out  NUM_REQ    per-requester accept
//  core_valid_o   out  1          to jpeg_core inport_valid_i
//  core_data_o    out  32         to jpeg_core inport_data_i
//  core_strb_o    out  4          to jpeg_core inport_strb_i
//  core_last_o    out  1          to jpeg_core inport_last_i
//  core_accept_i  in   1          from jpeg_core inport_accept_o
//  core_idle_i    in   1          from jpeg_core idle_o
//  owner_id_o     out  ID_W       requester owning the core (input and pixel output)
//  owner_valid_o  out  1          owner_id_o meaningful (XFER or DRAIN)
//  frame_cnt_o    out  NUM_REQ*16 per-requester completed-frame count (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; rr_ptr=0; drain counter=0; frame counters=0.
//  - Reset is asynchronous, at any time; a reset mid-frame abandons the frame.
//  - The integrator resets jpeg_core together with this block.
//  States:
//  - IDLE: if any req_valid_i bit is set, pick the first set bit at or after rr_ptr (circular).
//    Register gnt, go to XFER next cycle. No core_valid_o in IDLE (grant latency 1 cycle).
//  - XFER: combinational mux from requester gnt:
//    core_valid_o=req_valid_i[gnt]; data/strb/last likewise; req_accept_o[gnt]=core_accept_i.
//    All other req_accept_o bits are 0. A valid gap from the owner keeps the grant; there is no timeout.
//    On core_valid_o && core_accept_i && core_last_o: go to DRAIN and set rr_ptr=(gnt+1) mod NUM_REQ.
//    This also applies when the first beat is last.
//  - DRAIN: core_valid_o=0. Count consecutive cycles with core_idle_i=1; clear the count on any 0.
//    When count reaches IDLE_CYCLES, go to IDLE. The frame count for gnt increments on that edge.
//  - owner_valid_o=1 in XFER and DRAIN. owner_id_o=gnt, held stable from grant until IDLE.
//  Boundary rules:
//  - Simultaneous requests: round-robin from rr_ptr. No requester is granted twice while another waits.
//  - NUM_REQ=1: always grants 0; the DRAIN gating still applies.
//  - A request dropped while in IDLE before the grant registers is still granted (the grant is sticky).
//  - Frame counters wrap at 2^16.
// CONFIGURATION
//  JPEG_STREAM_ARB_STATS_EN defined: frame_cnt_o carries live 16-bit counters.
//  Not defined: frame_cnt_o is tied to 0 and no counter flops are built.
// STRUCTURE
//  jpeg_stream_arb_pkg: state enum {ST_IDLE, ST_XFER, ST_DRAIN}, data/strb width constants,
//    and the circular-priority pick function shared with the submodule.
//  Submodule jpeg_stream_arb_rr_pick: combinational circular priority picker.
//    Inputs: req vector, rr_ptr. Outputs: found, index.
// TESTING
//  1. Single requester 0, 3 beats, last on beat 3, core_accept_i=1:
//     grant 1 cycle after valid; 3 beats pass; DRAIN; after idle held 4 cycles, IDLE; frame_cnt[0]=1.
//  2. req_valid_i=4'b1111 at reset exit, each requester sends 1-beat frames:
//     grant order is 0,1,2,3,0.
//  3. Owner 2 mid-frame with core_accept_i toggling 1/0: beats are never duplicated or dropped.
//     req_accept_o is zero for requesters 0,1,3 throughout.
//  4. DRAIN with core_idle_i pattern 1,1,0,1,1,1,1: IDLE entered only after the last four 1s.
//     owner_id_o stays stable until then.
//  5. Assert rst_ni low mid-XFER: all outputs 0 asynchronously.
//     After release, the first grant goes to the lowest set req_valid_i bit (rr_ptr=0).
//  6. STATS_EN undefined: frame_cnt_o==0 after several frames. Defined: the counter wraps 16'hFFFF->0.

Source files
------------

// File: rtl/jpeg_stream_arb_pkg.sv
// Shared types and helpers for the frame-granular JPEG input stream arbiter.
// The optional statistics feature is enabled by JPEG_STREAM_ARB_STATS_EN.
package jpeg_stream_arb_pkg;

    localparam int DATA_W    = 32;
    localparam int STRB_W    = 4;
    localparam int CNT_W     = 16;
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // Walk offsets from the highest down so the smallest offset from ptr wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int                   num);
        pick_t                res;
        logic [MAX_IDX_W:0]   pos;
        res = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < num) begin
                pos = {1'b0, ptr} + (MAX_IDX_W + 1)'(i);
                if (pos >= (MAX_IDX_W + 1)'(num)) begin
                    pos = pos - (MAX_IDX_W + 1)'(num);
                end
                if (req[pos[MAX_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = pos[MAX_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/jpeg_stream_arb_rr_pick.sv
// Combinational circular-priority picker: first set request at or after rr_ptr_i.
module jpeg_stream_arb_rr_pick
    import jpeg_stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic               found_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [MAX_REQ-1:0]   req_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    pick_t                pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        ptr_ext                = MAX_IDX_W'(rr_ptr_i);
        pick                   = rr_pick(req_ext, ptr_ext, NUM_REQ);
    end

    assign found_o = pick.found;
    assign idx_o   = ID_W'(pick.idx);

endmodule

// File: rtl/jpeg_stream_arb.sv
// Frame-granular arbiter sharing one jpeg_core input among NUM_REQ requesters.
// Define JPEG_STREAM_ARB_STATS_EN to build the per-requester frame counters.
module jpeg_stream_arb
    import jpeg_stream_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int IDLE_CYCLES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ*STRB_W-1:0] req_strb_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_accept_o,
    output logic                      core_valid_o,
    output logic [DATA_W-1:0]         core_data_o,
    output logic [STRB_W-1:0]         core_strb_o,
    output logic                      core_last_o,
    input  logic                      core_accept_i,
    input  logic                      core_idle_i,
    output logic [ID_W-1:0]           owner_id_o,
    output logic                      owner_valid_o,
    output logic [NUM_REQ*CNT_W-1:0]  frame_cnt_o
);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]        drain_cnt_q, drain_cnt_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   next_ptr;
    logic              drain_done;

    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [STRB_W-1:0] sel_strb;

    jpeg_stream_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i    (req_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    // Compare against every legal index so a non-power-of-two NUM_REQ never indexes out of range.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q == ID_W'(k)) begin
                sel_valid = req_valid_i[k];
                sel_last  = req_last_i[k];
                sel_data  = req_data_i[k*DATA_W +: DATA_W];
                sel_strb  = req_strb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    assign next_ptr   = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
    assign drain_done = (state_q == ST_DRAIN) && core_idle_i &&
                        (({1'b0, drain_cnt_q} + 9'd1) >= 9'(IDLE_CYCLES));

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_ptr_d      = rr_ptr_q;
        drain_cnt_d   = drain_cnt_q;
        core_valid_o  = 1'b0;
        core_data_o   = '0;
        core_strb_o   = '0;
        core_last_o   = 1'b0;
        req_accept_o  = '0;
        owner_valid_o = (state_q != ST_IDLE);
        owner_id_o    = (state_q != ST_IDLE) ? gnt_q : '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                core_valid_o = sel_valid;
                core_data_o  = sel_data;
                core_strb_o  = sel_strb;
                core_last_o  = sel_last;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (gnt_q == ID_W'(k)) begin
                        req_accept_o[k] = core_accept_i;
                    end
                end
                if (sel_valid && core_accept_i && sel_last) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                    rr_ptr_d    = next_ptr;
                end
            end
            ST_DRAIN: begin
                // The core must report idle for an unbroken run before the next image may start.
                if (drain_done) begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = '0;
                end else if (core_idle_i) begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end else begin
                    drain_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef JPEG_STREAM_ARB_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q [NUM_REQ];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                frame_cnt_q[k] <= '0;
            end
        end else if (drain_done) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt_q == ID_W'(k)) begin
                    frame_cnt_q[k] <= frame_cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        frame_cnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            frame_cnt_o[k*CNT_W +: CNT_W] = frame_cnt_q[k];
        end
    end
`else
    assign frame_cnt_o = '0;
`endif

endmodule

// File: tb/tb_jpeg_stream_arb.sv
// Self-checking bench for jpeg_stream_arb: directed table, corner sequences and randomized traffic
// checked against a transaction-level reference model.
module tb_jpeg_stream_arb;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int IC  = 4;

    logic            clk;
    logic            rstN;
    logic [N-1:0]    reqValid;
    logic [N*32-1:0] reqData;
    logic [N*4-1:0]  reqStrb;
    logic [N-1:0]    reqLast;
    logic [N-1:0]    reqAccept;
    logic            coreValid;
    logic [31:0]     coreData;
    logic [3:0]      coreStrb;
    logic            coreLast;
    logic            coreAccept;
    logic            coreIdle;
    logic [IDW-1:0]  ownerId;
    logic            ownerValid;
    logic [N*16-1:0] frameCnt;

    jpeg_stream_arb #(
        .NUM_REQ     (N),
        .ID_W        (IDW),
        .IDLE_CYCLES (IC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .req_valid_i   (reqValid),
        .req_data_i    (reqData),
        .req_strb_i    (reqStrb),
        .req_last_i    (reqLast),
        .req_accept_o  (reqAccept),
        .core_valid_o  (coreValid),
        .core_data_o   (coreData),
        .core_strb_o   (coreStrb),
        .core_last_o   (coreLast),
        .core_accept_i (coreAccept),
        .core_idle_i   (coreIdle),
        .owner_id_o    (ownerId),
        .owner_valid_o (ownerValid),
        .frame_cnt_o   (frameCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the core, whether it is draining, and the round-robin start point.
    int     mOwner = -1;
    bit     mDrain = 1'b0;
    int     mRun = 0;
    int     mPtr = 0;
    int     mFrames [N];
    int     sbBeat [N];
    int     drvBeat [N];
    logic [N-1:0] accSeen = '0;

    typedef struct {
        logic [N-1:0] vec;
        int           expOwner;
    } rrVec_t;

    rrVec_t tbl [11];

    function automatic logic [31:0] word(input int k, input int b);
        return {8'(k), 8'h5A, 16'(b)};
    endfunction

    function automatic logic [3:0] strbOf(input int k, input int b);
        return 4'(b) ^ 4'(k);
    endfunction

    function automatic int rrPick(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] expFrameCnt();
        logic [63:0] e;
        e = '0;
`ifdef JPEG_STREAM_ARB_STATS_EN
        for (int k = 0; k < N; k++) e[k*16 +: 16] = 16'(mFrames[k]);
`endif
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        mOwner = -1;
        mDrain = 1'b0;
        mRun   = 0;
        mPtr   = 0;
        for (int k = 0; k < N; k++) mFrames[k] = 0;
    endtask

    // One clock cycle: refresh data, check outputs against the model, then let the edge happen.
    task automatic applyStimulus();
        logic [N-1:0] expAcc;
        for (int k = 0; k < N; k++) begin
            reqData[k*32 +: 32] = word(k, drvBeat[k]);
            reqStrb[k*4 +: 4]   = strbOf(k, drvBeat[k]);
        end
        #1;
        accSeen = reqAccept;
        expAcc  = '0;
        checkOutput("owner_valid", 64'(ownerValid), 64'(mOwner >= 0));
        checkOutput("owner_id", 64'(ownerId), 64'((mOwner >= 0) ? mOwner : 0));
        if (mOwner >= 0 && !mDrain) begin
            checkOutput("core_valid", 64'(coreValid), 64'(reqValid[mOwner]));
            checkOutput("core_data", 64'(coreData), 64'(reqData[mOwner*32 +: 32]));
            checkOutput("core_strb", 64'(coreStrb), 64'(reqStrb[mOwner*4 +: 4]));
            checkOutput("core_last", 64'(coreLast), 64'(reqLast[mOwner]));
            expAcc[mOwner] = coreAccept;
        end else begin
            checkOutput("core_valid_off", 64'(coreValid), 64'(0));
        end
        checkOutput("req_accept", 64'(reqAccept), 64'(expAcc));
        checkOutput("frame_cnt", 64'(frameCnt), expFrameCnt());

        for (int k = 0; k < N; k++) begin
            if (reqValid[k] && reqAccept[k]) drvBeat[k]++;
        end

        if (mOwner < 0) begin
            if (reqValid != '0) begin
                mOwner = rrPick(reqValid, mPtr);
                mDrain = 1'b0;
            end
        end else if (!mDrain) begin
            if (reqValid[mOwner] && coreAccept) begin
                checkOutput("beat_order", 64'(coreData), 64'(word(mOwner, sbBeat[mOwner])));
                sbBeat[mOwner]++;
                if (reqLast[mOwner]) begin
                    mDrain = 1'b1;
                    mRun   = 0;
                    mPtr   = (mOwner + 1) % N;
                end
            end
        end else begin
            mRun = coreIdle ? mRun + 1 : 0;
            if (mRun == IC) begin
                mFrames[mOwner] = (mFrames[mOwner] + 1) % 65536;
                mOwner = -1;
                mDrain = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rstN       = 1'b0;
        reqValid   = '0;
        reqLast    = '0;
        coreAccept = 1'b0;
        coreIdle   = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_outputs",
                    64'({coreValid, coreLast, ownerValid, ownerId, reqAccept, coreStrb}), 64'(0));
        checkOutput("reset_data", 64'(coreData), 64'(0));
        checkOutput("reset_frame_cnt", 64'(frameCnt), 64'(0));
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic drainWait(output int n);
        n = 0;
        while (ownerValid && n < 40) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_timeout", 64'(ownerValid), 64'(0));
    endtask

    task automatic runFrame(input logic [N-1:0] vec, input int expOwner, input string tag);
        int n;
        reqValid   = vec;
        reqLast    = vec;
        coreAccept = 1'b1;
        coreIdle   = 1'b1;
        applyStimulus();
        checkOutput(tag, 64'(ownerId), 64'(expOwner));
        applyStimulus();
        reqValid = '0;
        reqLast  = '0;
        drainWait(n);
    endtask

    initial begin
        int n;
        int got;
        int framesLeft [N];
        int bif [N];
        int flen [N];
        bit done;
        bit allDone;
        logic [IDW:0] pat;

        rstN       = 1'b0;
        reqValid   = '0;
        reqLast    = '0;
        reqData    = '0;
        reqStrb    = '0;
        coreAccept = 1'b0;
        coreIdle   = 1'b0;
        for (int k = 0; k < N; k++) begin
            sbBeat[k]  = 0;
            drvBeat[k] = 0;
        end
        resetModel();
        @(negedge clk);
        doReset();

        $display("[TB] single requester, three beats");
        reqValid   = 4'b0001;
        reqLast    = 4'b0000;
        coreAccept = 1'b1;
        coreIdle   = 1'b1;
        applyStimulus();
        checkOutput("t1_grant_latency", 64'({ownerValid, ownerId}), 64'(3'b100));
        applyStimulus();
        applyStimulus();
        reqLast = 4'b0001;
        applyStimulus();
        reqValid = '0;
        reqLast  = '0;
        drainWait(n);
        checkOutput("t1_drain_len", 64'(n), 64'(IC));
`ifdef JPEG_STREAM_ARB_STATS_EN
        checkOutput("t1_frame_cnt0", 64'(frameCnt[15:0]), 64'(1));
`else
        checkOutput("t1_frame_cnt0", 64'(frameCnt[15:0]), 64'(0));
`endif

        $display("[TB] round-robin table");
        doReset();
        tbl[0]  = '{4'b1111, 0};
        tbl[1]  = '{4'b1111, 1};
        tbl[2]  = '{4'b1111, 2};
        tbl[3]  = '{4'b1111, 3};
        tbl[4]  = '{4'b1111, 0};
        tbl[5]  = '{4'b0100, 2};
        tbl[6]  = '{4'b1001, 3};
        tbl[7]  = '{4'b0011, 0};
        tbl[8]  = '{4'b0010, 1};
        tbl[9]  = '{4'b0001, 0};
        tbl[10] = '{4'b1000, 3};
        for (int i = 0; i < 11; i++) begin
            runFrame(tbl[i].vec, tbl[i].expOwner, "rr_order");
        end
`ifdef JPEG_STREAM_ARB_STATS_EN
        checkOutput("table_frame_cnt", 64'(frameCnt), 64'h0003_0002_0002_0004);
`else
        checkOutput("table_frame_cnt", 64'(frameCnt), 64'(0));
`endif

        $display("[TB] sticky grant, valid gap, accept toggling on owner 2");
        reqValid   = 4'b0100;
        reqLast    = '0;
        coreAccept = 1'b1;
        coreIdle   = 1'b1;
        applyStimulus();
        reqValid = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("t3_sticky_owner", 64'({ownerValid, ownerId}), 64'(3'b110));
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            reqValid   = 4'b0100;
            reqLast    = (got == 3) ? 4'b0100 : 4'b0000;
            coreAccept = ((c % 2) == 1);
            applyStimulus();
            if (accSeen[2]) got++;
            checkOutput("t3_others_accept", 64'(accSeen & 4'b1011), 64'(0));
        end
        checkOutput("t3_beats", 64'(got), 64'(4));
        reqValid = '0;
        reqLast  = '0;
        drainWait(n);

        $display("[TB] drain idle pattern 1,1,0,1,1,1,1");
        reqValid   = 4'b1000;
        reqLast    = 4'b1000;
        coreAccept = 1'b1;
        coreIdle   = 1'b0;
        applyStimulus();
        applyStimulus();
        reqValid = '0;
        reqLast  = '0;
        for (int i = 0; i < 7; i++) begin
            coreIdle = (i != 2);
            applyStimulus();
            checkOutput("t4_owner_valid", 64'(ownerValid), 64'(i < 6));
            pat = (i < 6) ? 3'b111 : 3'b000;
            checkOutput("t4_owner_id", 64'({ownerValid, ownerId}), 64'(pat));
        end

        $display("[TB] asynchronous reset mid-transfer");
        runFrame(4'b0010, 1, "t5_pre_frame");
        reqValid   = 4'b0100;
        reqLast    = '0;
        coreAccept = 1'b1;
        applyStimulus();
        applyStimulus();
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t5_async_ctrl",
                    64'({coreValid, coreLast, ownerValid, ownerId, reqAccept, coreStrb}), 64'(0));
        checkOutput("t5_async_data", 64'(coreData), 64'(0));
        checkOutput("t5_async_cnt", 64'(frameCnt), 64'(0));
        resetModel();
        reqValid = '0;
        @(negedge clk);
        rstN     = 1'b1;
        reqValid = 4'b1001;
        reqLast  = '0;
        applyStimulus();
        checkOutput("t5_first_grant", 64'({ownerValid, ownerId}), 64'(3'b100));
        reqLast = 4'b0001;
        applyStimulus();
        reqValid = '0;
        reqLast  = '0;
        drainWait(n);

        $display("[TB] randomized traffic");
        for (int k = 0; k < N; k++) begin
            framesLeft[k] = int'($urandom_range(3, 6));
            bif[k]        = 0;
            flen[k]       = int'($urandom_range(1, 4));
        end
        accSeen = '0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            allDone = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (reqValid[k] && accSeen[k]) begin
                    if (bif[k] == flen[k] - 1) begin
                        bif[k]  = 0;
                        flen[k] = int'($urandom_range(1, 4));
                        framesLeft[k]--;
                    end else begin
                        bif[k]++;
                    end
                end
                if (framesLeft[k] == 0) begin
                    reqValid[k] = 1'b0;
                end else begin
                    allDone = 1'b0;
                    if (!(reqValid[k] && !accSeen[k])) begin
                        reqValid[k] = ($urandom_range(0, 3) != 0);
                    end
                end
                reqLast[k] = (bif[k] == flen[k] - 1);
            end
            if (allDone && mOwner < 0) begin
                done = 1'b1;
            end else begin
                coreAccept = ($urandom_range(0, 9) < 7);
                coreIdle   = ($urandom_range(0, 9) < 8);
                applyStimulus();
            end
        end
        checkOutput("rand_complete", 64'(done), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
